// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
// pc_sequencer: owns the architectural PC and drives the next-PC mux select.
// Boots at RESET_PC, then steps by 4 or redirects to an execute-stage target.
// Wrong-path instructions are killed for FLUSH_DEPTH unstalled cycles after a redirect.
// A misaligned redirect target halts fetch until reset.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BOOT_CYCLES = 4,
   parameter int          FLUSH_DEPTH = 2,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic             redirect_fwd,
   input  logic [31:0]      pc_next,
   output logic [1:0]       pc_sel,
   output logic [31:0]      pc,
   output logic             pc_we,
   output logic             fetch_valid,
   output logic             kill,
   output logic             misaligned,
   output logic [CNT_W-1:0] redirect_count
);

   localparam logic [7:0] BOOT_LAST  = 8'(BOOT_CYCLES - 1);
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_FLUSH,
      ST_HALT
   } state_t;

   state_t     state;
   logic [7:0] boot_cnt;
   logic [2:0] flush_cnt;
   logic       active;
   logic       redir;
   logic       redir_bad;

   // Mux select and PC load enable; redirects are only honoured while fetching.
   always_comb begin
      active    = (state == ST_RUN) || (state == ST_FLUSH);
      redir     = active && redirect_valid;
      redir_bad = redir && (pc_next[1:0] != 2'b00);
      pc_sel    = 2'd0;
      if (redir) begin
         pc_sel = redirect_fwd ? 2'd2 : 2'd1;
      end
      // An aligned redirect overrides stall; a misaligned one never loads.
      pc_we = active && (redir ? !redir_bad : !stall);
   end

   // Sequencer FSM with registered fetch_valid/kill and the sticky status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_BOOT;
         boot_cnt       <= 8'd0;
         flush_cnt      <= 3'd0;
         misaligned     <= 1'b0;
         redirect_count <= '0;
         fetch_valid    <= 1'b0;
         kill           <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               // Boot countdown runs regardless of stall or redirects.
               boot_cnt <= boot_cnt + 8'd1;
               if (boot_cnt == BOOT_LAST) begin
                  state       <= ST_RUN;
                  fetch_valid <= 1'b1;
               end
            end
            ST_RUN, ST_FLUSH: begin
               if (redir_bad) begin
                  state       <= ST_HALT;
                  misaligned  <= 1'b1;
                  fetch_valid <= 1'b0;
                  kill        <= 1'b1;
               end else if (redir) begin
                  state     <= ST_FLUSH;
                  flush_cnt <= FLUSH_LOAD;
                  kill      <= 1'b1;
                  if (redirect_count != '1) begin
                     redirect_count <= redirect_count + 1'b1;
                  end
               end else if ((state == ST_FLUSH) && !stall) begin
                  // Only unstalled cycles drain the wrong-path window.
                  flush_cnt <= flush_cnt - 3'd1;
                  if (flush_cnt == 3'd1) begin
                     state <= ST_RUN;
                     kill  <= 1'b0;
                  end
               end
            end
            ST_HALT: begin
               // Frozen until reset; misaligned and kill stay asserted.
               state <= ST_HALT;
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

   // Architectural PC register, loaded from the external next-PC mux.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (pc_we) begin
         pc <= pc_next;
      end
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control block that sequences the core's next-PC selection mux and owns the architectural PC register. It holds the PC at the boot address after reset, then drives the mux select each cycle: sequential (+4), redirect from the ALU result, or redirect from the forwarded ALU result. It registers the selected next PC and signals the fetch and pipeline stages (fetch valid, kill of wrong-path instructions, alignment fault). It sits between the fetch stage and the execute-stage branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and held during boot
BOOT_CYCLES, 4, cycles after reset release before the first fetch (legal range 1-255)
FLUSH_DEPTH, 2, number of non-stalled cycles kill stays asserted after a redirect (legal range 1-7)
CNT_W, 16, width of the redirect performance counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hazard/memory stall; freezes PC and flush countdown
redirect_valid  in  1  execute stage resolved a taken branch or jump this cycle
redirect_fwd  in  1  qualifies redirect_valid; target comes from the forwarded ALU path
pc_next  in  32  output of the next-PC mux (combinational function of pc_sel)
pc_sel  out  2  mux select: 0 = add_4, 1 = alu, 2 = alu_forward; 3 is never driven
pc  out  32  registered architectural PC
pc_we  out  1  PC register loads pc_next at this rising edge
fetch_valid  out  1  pc is a valid fetch address this cycle
kill  out  1  squash younger in-flight instructions
misaligned  out  1  sticky: a redirect target had pc_next[1:0] != 0
redirect_count  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT; pc=RESET_PC; boot counter=0; flush counter=0; misaligned=0; redirect_count=0. Registered outputs go low immediately.
- States: BOOT, RUN, FLUSH, HALT.
- pc_sel is combinational:
  - 2 when redirect_valid and redirect_fwd in RUN or FLUSH.
  - 1 when redirect_valid and not redirect_fwd in RUN or FLUSH.
  - 0 otherwise.
- BOOT:
  - fetch_valid=0, kill=0, pc_we=0.
  - The counter increments each cycle.
  - When the counter reaches BOOT_CYCLES-1, the next state is RUN.
  - redirect_valid is ignored. stall does not pause the count.
- RUN: fetch_valid=1 and kill=0. Priority per cycle is:
  1. Redirect with pc_next[1:0]!=0: pc_we=0, misaligned set, next state HALT, redirect not counted.
  2. Aligned redirect: pc_we=1 (even if stall=1), pc<=pc_next, redirect_count increments (saturating at all-ones), flush counter<=FLUSH_DEPTH, next state FLUSH.
  3. stall: pc_we=0, pc held.
  4. Otherwise: pc_we=1 with pc_sel=0, so pc<=pc+4 via the mux.
- FLUSH:
  - kill=1 and fetch_valid=1; fetching proceeds from the new target.
  - PC update rules are identical to RUN.
  - The flush counter decrements only on cycles with stall=0. When it reaches 1 with stall=0, the next state is RUN.
  - A new aligned redirect in FLUSH reloads the counter to FLUSH_DEPTH and stays in FLUSH.
  - A misaligned redirect goes to HALT.
- HALT:
  - fetch_valid=0, kill=1, pc_we=0, pc frozen.
  - misaligned stays 1; only rst leaves HALT.
- pc_we is combinational and is exactly the load enable of the internal pc register.
- Wrap-around: pc+4 from 32'hFFFF_FFFC wraps to 0 with no flag.
- Reset asserted mid-FLUSH or mid-stall aborts immediately to BOOT values.

Test Plan:
- Release rst at cycle 0 with RESET_PC=32'h100, BOOT_CYCLES=4 -> fetch_valid=0 for 4 cycles, then 1; pc=32'h100 on the first valid fetch, then 32'h104, 32'h108 on successive edges.
- In RUN at pc=32'h200, pulse redirect_valid=1, redirect_fwd=0, pc_next=32'h80 -> pc_sel=1 that cycle; pc=32'h80 next; kill high for exactly 2 cycles; redirect_count=1.
- Redirect with redirect_fwd=1 and stall=1 at the same time, target 32'h40 -> pc_sel=2, pc_we=1, pc=32'h40; then hold stall 3 cycles -> kill stays high through the stall, deasserts 2 unstalled cycles later.
- Redirect to 32'h42 -> pc unchanged, misaligned=1, fetch_valid=0 and kill=1 thereafter; pulse rst -> misaligned=0, BOOT restarts.
- Back-to-back redirects to 32'h10 then 32'h20 during FLUSH -> counter reloads; kill lasts 2 unstalled cycles after the second redirect; redirect_count=2.
- With CNT_W=4, issue 20 redirects -> redirect_count saturates at 4'hF; also start at pc=32'hFFFF_FFFC, step once -> pc=0.
